// File: rtl/lsu16_pkg.sv
// lsu16_pkg: shared constants for the 16-bit load/store unit.
// Op codes, FSM state encoding and the fixed word/byte widths.
package lsu16_pkg;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } lsuState_t;

    // Any code outside the five defined ops is answered with an error.
    function automatic logic isLegalOp(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/lsu16_rmw_if.sv
// lsu16_rmw_if: request, response and memory-port signals of the load/store unit.
// slave  = the load/store unit itself.
// master = everything around it (requester, response consumer and the memory).
interface lsu16_rmw_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/lsu16_byte_merge.sv
// lsu16_byte_merge: combinational byte handling for the load/store unit.
// The memory returns {mem[a], mem[a+1]}, so the addressed byte is always [15:8].
// Loads pick the word or extend that byte; SB builds {new byte, old mem[a+1]}.
module lsu16_byte_merge
    import lsu16_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rdata,
    input  logic [BYTE_W-1:0] wbyte,
    output logic [DATA_W-1:0] loadData,
    output logic [DATA_W-1:0] mergeData
);
    logic [BYTE_W-1:0] hiByte;

    assign hiByte    = rdata[DATA_W-1 -: BYTE_W];
    assign mergeData = {wbyte, rdata[BYTE_W-1:0]};

    // Select the load result for the registered op; stores read back as zero.
    always_comb begin
        // NOTE: default assignment first so every path drives loadData and no latch is inferred.
        loadData = '0;
        case (op)
            OP_LW:   loadData = rdata;
            OP_LB:   loadData = {{(DATA_W-BYTE_W){hiByte[BYTE_W-1]}}, hiByte};
            OP_LBU:  loadData = {{(DATA_W-BYTE_W){1'b0}}, hiByte};
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/lsu16_rmw.sv
// lsu16_rmw: load/store unit driving one port of a 16-bit byte-addressed memory.
// Word/byte loads and stores over valid/ready, one response per request.
// Byte stores are read-modify-write: read the word, write {new byte, old low byte}.
// Build option: define LSU_ALIGN_CHECK_EN to reject LW/SW at odd addresses.
module lsu16_rmw #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8
) (
    input  logic       clk,
    input  logic       rstz,
    lsu16_rmw_if.slave bus,
    inout  wire        dvdd,
    inout  wire        dgnd
);
    import lsu16_pkg::*;

    lsuState_t         state;
    logic [2:0]        opReg;
    logic [BYTE_W-1:0] wbyteReg;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] mergeData;
    logic              reqReject;
    logic              unusedSupply;

    // Supply pins only pass through this block.
    assign unusedSupply = dvdd ^ dgnd;
    assign reqAddr      = bus.req_addr;

`ifdef LSU_ALIGN_CHECK_EN
    assign reqReject = !isLegalOp(bus.req_op) ||
                       (reqAddr[0] && ((bus.req_op == OP_LW) || (bus.req_op == OP_SW)));
`else
    assign reqReject = !isLegalOp(bus.req_op);
`endif

    lsu16_byte_merge merge (
        .op        (opReg),
        .rdata     (bus.mem_rdata),
        .wbyte     (wbyteReg),
        .loadData  (loadData),
        .mergeData (mergeData)
    );

    // Request FSM; every output is registered and reset drops the request in flight.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state         <= IDLE;
            opReg         <= OP_LW;
            wbyteReg      <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        opReg         <= bus.req_op;
                        wbyteReg      <= bus.req_wdata[BYTE_W-1:0];
                        bus.req_ready <= 1'b0;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b0;
                        if (reqReject) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_valid <= 1'b1;
                            state         <= RSP;
                        end else if (bus.req_op == OP_SW) begin
                            bus.mem_addr  <= reqAddr;
                            bus.mem_wdata <= bus.req_wdata;
                            bus.mem_we    <= 1'b1;
                            state         <= WR;
                        end else begin
                            bus.mem_addr <= reqAddr;
                            state        <= RD;
                        end
                    end
                end
                RD: begin
                    if (opReg == OP_SB) begin
                        bus.mem_wdata <= mergeData;
                        bus.mem_we    <= 1'b1;
                        state         <= WR;
                    end else begin
                        bus.rsp_data  <= loadData;
                        bus.rsp_valid <= 1'b1;
                        state         <= RSP;
                    end
                end
                WR: begin
                    bus.mem_we    <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state         <= RSP;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
